// File: rtl/image_row_rd_ctrl.sv
// image_row_rd_ctrl: read-side sequencer for the image row buffer RAM.
// Waits for a resident chunk, reads it byte-by-byte through the RAM read port,
// packs every 8 bytes into a 64-bit word (first byte in [7:0]) and offers the
// word with its DDR byte address on a valid/ready stream. After the last word
// of a chunk it pulses rd_row_done, then idles one extra cycle so that the
// buffer's registered pkt_ready has settled before the next launch decision.
module image_row_rd_ctrl #(
    parameter int unsigned CHUNK_BYTES      = 256,   // multiple of 8, divides 2048
    parameter int unsigned CHUNKS_PER_FRAME = 18,
    parameter int unsigned RD_LAT           = 2,     // rd_addr -> rd_data, >= 1
    parameter logic [27:0] BASE_ADDR        = 28'h000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_calib_complete,
    input  logic        pkt_ready,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        rd_row_done,
    output logic [63:0] wr_data,
    output logic [27:0] wr_addr,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned WORDS_PER_CHUNK = CHUNK_BYTES / 8;
    localparam int unsigned WC_W = (WORDS_PER_CHUNK > 1) ? $clog2(WORDS_PER_CHUNK) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PUSH,
        S_DONE,
        S_GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]        issue_cnt;   // reads issued for the current word, 0..8
    logic [2:0]        lane;        // byte lane that the next captured byte fills
    logic [RD_LAT-1:0] issue_vld;   // issue-valid pipeline aligned with RAM latency
    logic [WC_W-1:0]   word_cnt;    // word index inside the current chunk
    logic [11:0]       chunk_cnt;   // chunk index inside the current frame

    logic issue;
    logic capture;
    logic accept;
    logic last_word;
    logic last_chunk;

    assign issue      = (state == S_FETCH) && (issue_cnt < 4'd8);
    assign capture    = (state == S_FETCH) && issue_vld[RD_LAT-1];
    assign accept     = (state == S_PUSH) && wr_ready;
    assign last_word  = (word_cnt == WC_W'(WORDS_PER_CHUNK - 1));
    assign last_chunk = (chunk_cnt == 12'(CHUNKS_PER_FRAME - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived stream/handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt   = state;
        wr_valid    = 1'b0;
        rd_row_done = 1'b0;
        busy        = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                // Calibration only gates the launch; a later drop is ignored.
                if (init_calib_complete && pkt_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (capture && (lane == 3'd7)) begin
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                wr_valid = 1'b1;
                if (accept) begin
                    state_nxt = last_word ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                rd_row_done = 1'b1;
                state_nxt   = S_GAP;
            end
            S_GAP: begin
                // pkt_ready is still stale here; decide again from IDLE.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read issue, byte packing, write addressing and frame accounting.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every right-hand side sees the
        // value from before this edge, matching the hardware flop behaviour.
        if (rst) begin
            rd_addr    <= '0;
            issue_cnt  <= '0;
            lane       <= '0;
            issue_vld  <= '0;
            wr_data    <= '0;
            wr_addr    <= BASE_ADDR;
            word_cnt   <= '0;
            chunk_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            issue_vld[0] <= issue;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                issue_vld[i] <= issue_vld[i-1];
            end

            // rd_addr runs freely and wraps at 2047 by its own width.
            if (issue) begin
                rd_addr   <= rd_addr + 11'd1;
                issue_cnt <= issue_cnt + 4'd1;
            end else if (state != S_FETCH) begin
                issue_cnt <= '0;
            end

            // lane wraps 7 -> 0 by width, ready for the next word.
            if (capture) begin
                wr_data[{lane, 3'b000} +: 8] <= rd_data;
                lane                         <= lane + 3'd1;
            end

            if (accept) begin
                if (last_word) begin
                    word_cnt <= '0;
                    if (last_chunk) begin
                        chunk_cnt  <= '0;
                        wr_addr    <= BASE_ADDR;
                        frame_done <= 1'b1;
                    end else begin
                        chunk_cnt <= chunk_cnt + 12'd1;
                        wr_addr   <= wr_addr + 28'd8;
                    end
                end else begin
                    word_cnt <= word_cnt + WC_W'(1);
                    wr_addr  <= wr_addr + 28'd8;
                end
            end
        end
    end

endmodule
